multi_button_event_detector: RTL

- Parametrised successor to the single-channel debouncer plus one-shot pair.
- Handles CHANNELS independent push-button inputs. Per channel it provides:
  - input synchronisation and optional inversion;
  - counter-based debounce;
  - one-cycle press and release pulses;
  - long-press detection;
  - optional auto-repeat while the button is held.
- Sits between the board button pins and the FSM and counter logic that consume button events.

---
 rtl/multi_button_event_detector_if.sv | 28 ++
 rtl/multi_button_event_detector.sv | 138 +++++++++++++
 2 files changed

// File: rtl/multi_button_event_detector_if.sv
// Button event bus: raw pins in, debounced level and one-cycle event pulses out.
//   signal           raw button pins (asynchronous to clk)
//   level            debounced level, 1 = pressed
//   press_pulse      one-cycle pulse on an accepted press
//   release_pulse    one-cycle pulse on an accepted release
//   long_press_pulse one-cycle pulse once per press after the long-press time
//   repeat_pulse     periodic one-cycle pulse while held beyond the long press
// master = pin driver / event consumer side, slave = the detector.
interface multi_button_event_detector_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] signal;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic [CHANNELS-1:0] long_press_pulse;
  logic [CHANNELS-1:0] repeat_pulse;

  modport master (
    output signal,
    input  level, press_pulse, release_pulse, long_press_pulse, repeat_pulse
  );

  modport slave (
    input  signal,
    output level, press_pulse, release_pulse, long_press_pulse, repeat_pulse
  );
endinterface

// File: rtl/multi_button_event_detector.sv
// Multi-channel push-button front end: per channel a 2-flop synchroniser with
// optional inversion, counter debounce, press/release one-shots, long-press
// detection and optional auto-repeat. All outputs are registered.
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  slave side of multi_button_event_detector_if (pins in, events out)
module multi_button_event_detector #(
  parameter int unsigned CHANNELS             = 4,
  parameter int unsigned INVERT_LOGIC         = 0,
  parameter int unsigned DEBOUNCE_THRESHOLD   = 5000,
  parameter int unsigned LONG_PRESS_THRESHOLD = 50000000,
  parameter int unsigned REPEAT_PERIOD        = 10000000,
  parameter int unsigned REPEAT_EN            = 1
) (
  input logic                            clk,
  input logic                            rst,
  multi_button_event_detector_if.slave   bus
);

  localparam int unsigned DB_W     = $clog2(DEBOUNCE_THRESHOLD + 1);
  localparam int unsigned HOLD_MAX = (LONG_PRESS_THRESHOLD > REPEAT_PERIOD) ?
                                     LONG_PRESS_THRESHOLD : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic        IDLE_PIN = 1'(INVERT_LOGIC);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_THRESHOLD - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_THRESHOLD - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]        sync_q;
    logic              s;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              level_q, level_d;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;

    // Synchronised, polarity-corrected pin (1 = pressed)
    assign s = sync_q[1] ^ IDLE_PIN;

    // Debounce and event FSM next-state; level change and its event share an edge
    always_comb begin
      db_cnt_d  = '0;
      level_d   = level_q;
      state_d   = state_q;
      hold_d    = hold_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;

      if (s != level_q) begin
        if (db_cnt_q == DB_LAST) level_d  = s;
        else                     db_cnt_d = db_cnt_q + DB_ONE;
      end

      // Release wins over any long-press/repeat due on the same edge
      if (level_q && !level_d) begin
        release_d = 1'b1;
        state_d   = IDLE;
        hold_d    = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!level_q && level_d) begin
              press_d = 1'b1;
              hold_d  = HOLD_ONE;
              state_d = PRESSED;
            end
          end
          PRESSED: begin
            if (hold_q == LONG_LAST) begin
              long_d  = 1'b1;
              hold_d  = '0;
              state_d = HELD;
            end else begin
              hold_d = hold_q + HOLD_ONE;
            end
          end
          HELD: begin
            if (REPEAT_EN == 0) begin
              hold_d = '0;
            end else if (hold_q == REP_LAST) begin
              repeat_d = 1'b1;
              hold_d   = '0;
            end else begin
              hold_d = hold_q + HOLD_ONE;
            end
          end
          default: begin
            state_d = IDLE;
            hold_d  = '0;
          end
        endcase
      end
    end

    // State register; synchroniser resets to the idle pin value
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q    <= {2{IDLE_PIN}};
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        state_q   <= IDLE;
        hold_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        sync_q    <= {sync_q[0], bus.signal[i]};
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        state_q   <= state_d;
        hold_q    <= hold_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
      end
    end

    assign bus.level[i]            = level_q;
    assign bus.press_pulse[i]      = press_q;
    assign bus.release_pulse[i]    = release_q;
    assign bus.long_press_pulse[i] = long_q;
    assign bus.repeat_pulse[i]     = repeat_q;
  end

endmodule
